// File: rtl/mouse_pkg.sv
// Shared PS/2 mouse definitions: receiver FSM states, frame constants, error bit indices.
package mouse_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP,
    EMIT
  } state_t;

  localparam int unsigned TIMEOUT_DEFAULT = 50000;

  localparam int unsigned ERR_PARITY = 0;
  localparam int unsigned ERR_STOP   = 1;

  localparam int unsigned DATA_BITS  = 8;
  localparam logic        ODD_PARITY = 1'b1;

  // True when data plus parity bit do not contain an odd number of ones.
  function automatic logic parity_error(input logic [DATA_BITS-1:0] d, input logic p);
    return (^d ^ p) != ODD_PARITY;
  endfunction

endpackage

// File: rtl/ps2_edge_sync.sv
// Two-flop synchronisers for the PS/2 clock and data pads plus a falling-edge
// detector on the synchronised clock. All flops reset to the idle-high level.
module ps2_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic fall,
  output logic data_sync
);

  logic [1:0] clk_sync;
  logic [1:0] dat_sync;
  logic       clk_dly;

  // Synchronise both pad lines and keep one extra delayed copy of the clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_dly  <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
      clk_dly  <= clk_sync[1];
    end
  end

  assign fall      = clk_dly & ~clk_sync[1];
  assign data_sync = dat_sync[1];

endmodule

// File: rtl/mouse_receiver.sv
// PS/2 device-to-host receiver: deserialises start/8 data/odd parity/stop frames,
// emits each byte with a one-cycle ready strobe and a parity/stop error code.
module mouse_receiver
  import mouse_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
  parameter int unsigned CNT_W   = 16
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CLK_MOUSE_IN,
  input  logic       DATA_MOUSE_IN,
  input  logic       READ_ENABLE,
  output logic [7:0] BYTE_READ,
  output logic [1:0] BYTE_ERROR_CODE,
  output logic       BYTE_READY
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  state_t               state, state_nxt;
  logic [DATA_BITS-1:0] shift_q, shift_nxt;
  logic [2:0]           bit_cnt, bit_cnt_nxt;
  logic                 parity_q, parity_nxt;
  logic                 stop_q, stop_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [7:0]           byte_nxt;
  logic [1:0]           code_nxt;
  logic                 ready_nxt;
  logic                 fall;
  logic                 data;

  ps2_edge_sync u_sync (
    .clk       (CLK),
    .reset     (RESET),
    .ps2_clk   (CLK_MOUSE_IN),
    .ps2_data  (DATA_MOUSE_IN),
    .fall      (fall),
    .data_sync (data)
  );

  // Next-state and datapath update; abort on READ_ENABLE low, then fall beats timeout.
  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift_q;
    bit_cnt_nxt = bit_cnt;
    parity_nxt  = parity_q;
    stop_nxt    = stop_q;
    cnt_nxt     = cnt;
    byte_nxt    = BYTE_READ;
    code_nxt    = BYTE_ERROR_CODE;
    ready_nxt   = 1'b0;

    if (state != IDLE && !READ_ENABLE) begin
      state_nxt   = IDLE;
      cnt_nxt     = '0;
      bit_cnt_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          cnt_nxt = '0;
          if (READ_ENABLE && fall && !data) begin
            state_nxt   = DATA;
            bit_cnt_nxt = '0;
          end
        end
        DATA, PARITY, STOP: begin
          if (fall) begin
            cnt_nxt = '0;
            if (state == DATA) begin
              shift_nxt[bit_cnt] = data;
              if (bit_cnt == 3'd7) begin
                bit_cnt_nxt = '0;
                state_nxt   = PARITY;
              end else begin
                bit_cnt_nxt = bit_cnt + 3'd1;
              end
            end else if (state == PARITY) begin
              parity_nxt = data;
              state_nxt  = STOP;
            end else begin
              stop_nxt  = data;
              state_nxt = EMIT;
            end
          end else if (cnt >= TIMEOUT_CNT) begin
            state_nxt   = IDLE;
            cnt_nxt     = '0;
            bit_cnt_nxt = '0;
          end else if (cnt != '1) begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        EMIT: begin
          byte_nxt             = shift_q;
          code_nxt[ERR_PARITY] = parity_error(shift_q, parity_q);
          code_nxt[ERR_STOP]   = ~stop_q;
          ready_nxt            = 1'b1;
          state_nxt            = IDLE;
          cnt_nxt              = '0;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state           <= IDLE;
      shift_q         <= '0;
      bit_cnt         <= '0;
      parity_q        <= 1'b0;
      stop_q          <= 1'b0;
      cnt             <= '0;
      BYTE_READ       <= '0;
      BYTE_ERROR_CODE <= '0;
      BYTE_READY      <= 1'b0;
    end else begin
      state           <= state_nxt;
      shift_q         <= shift_nxt;
      bit_cnt         <= bit_cnt_nxt;
      parity_q        <= parity_nxt;
      stop_q          <= stop_nxt;
      cnt             <= cnt_nxt;
      BYTE_READ       <= byte_nxt;
      BYTE_ERROR_CODE <= code_nxt;
      BYTE_READY      <= ready_nxt;
    end
  end

endmodule
